// File: rtl/mixer_mult_sched.sv
// Round-robin scheduler sharing one signed 16x24 multiplier between the L/R mixer channels.
// Optional build macro MIXER_SCHED_SAT_EN: saturate the single overflowing product instead of wrapping.
module mixer_mult_sched #(
    parameter int MUL_LAT = 2,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [15:0] lo_sample,
    input  logic        lo_strobe,
    input  logic        req_l,
    input  logic [23:0] data_l,
    output logic        ack_l,
    input  logic        req_r,
    input  logic [23:0] data_r,
    output logic        ack_r,
    output logic [23:0] o_data_l,
    output logic        o_valid_l,
    output logic [23:0] o_data_r,
    output logic        o_valid_r,
    output logic        busy,
    output logic [1:0]  overrun,
    input  logic        clr_overrun
);

    logic        buf_l_full;
    logic        buf_r_full;
    logic [23:0] buf_l;
    logic [23:0] buf_r;
    logic        rr;

    logic        grant_l;
    logic        grant_r;
    logic        cap_l;
    logic        cap_r;
    logic        drop_l;
    logic        drop_r;

    logic [23:0]        issue_data;
    logic signed [39:0] lo_ext;
    logic signed [39:0] data_ext;
    logic signed [39:0] prod;
    logic [23:0]        issue_res;
    logic               unused_prod_bits;

    logic        pipe_valid [MUL_LAT];
    logic        pipe_tag   [MUL_LAT];
    logic [23:0] pipe_res   [MUL_LAT];
    logic        pipe_any;

    // rr only breaks ties; a lone full buffer is always granted on a strobe.
    always_comb begin
        grant_l = 1'b0;
        grant_r = 1'b0;
        if (lo_strobe) begin
            if (buf_l_full && buf_r_full) begin
                grant_l = ~rr;
                grant_r = rr;
            end else begin
                grant_l = buf_l_full;
                grant_r = buf_r_full;
            end
        end
    end

    // A buffer draining at this edge can take a new sample on the same edge.
    assign cap_l  = req_l & (~buf_l_full | grant_l);
    assign cap_r  = req_r & (~buf_r_full | grant_r);
    assign drop_l = req_l & buf_l_full & ~grant_l;
    assign drop_r = req_r & buf_r_full & ~grant_r;

    assign issue_data = grant_r ? buf_r : buf_l;
    assign lo_ext     = {{24{lo_sample[15]}}, lo_sample};
    assign data_ext   = {{16{issue_data[23]}}, issue_data};
    assign prod       = lo_ext * data_ext;

`ifdef MIXER_SCHED_SAT_EN
    always_comb begin
        issue_res = prod[38:15];
        if (prod[39] != prod[38]) begin
            issue_res = prod[39] ? 24'h800000 : 24'h7FFFFF;
        end
    end
`else
    assign issue_res = prod[38:15];
`endif

    assign unused_prod_bits = ^{prod[39], prod[14:0]};

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            buf_l_full <= 1'b0;
            buf_r_full <= 1'b0;
            buf_l      <= 24'd0;
            buf_r      <= 24'd0;
            rr         <= RR_INIT;
            ack_l      <= 1'b0;
            ack_r      <= 1'b0;
            overrun    <= 2'b00;
        end else begin
            ack_l <= cap_l;
            ack_r <= cap_r;

            if (cap_l) begin
                buf_l      <= data_l;
                buf_l_full <= 1'b1;
            end else if (grant_l) begin
                buf_l_full <= 1'b0;
            end

            if (cap_r) begin
                buf_r      <= data_r;
                buf_r_full <= 1'b1;
            end else if (grant_r) begin
                buf_r_full <= 1'b0;
            end

            if (grant_l) begin
                rr <= 1'b1;
            end else if (grant_r) begin
                rr <= 1'b0;
            end

            // A new drop on the same edge as a clear keeps its flag.
            overrun[0] <= drop_l | (overrun[0] & ~clr_overrun);
            overrun[1] <= drop_r | (overrun[1] & ~clr_overrun);
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_tag[i]   <= 1'b0;
                pipe_res[i]   <= 24'd0;
            end
        end else begin
            pipe_valid[0] <= grant_l | grant_r;
            pipe_tag[0]   <= grant_r;
            pipe_res[0]   <= issue_res;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
                pipe_res[i]   <= pipe_res[i-1];
            end
        end
    end

    // The tag steers each result to exactly one channel, so valids never coincide.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            o_valid_l <= 1'b0;
            o_valid_r <= 1'b0;
            o_data_l  <= 24'd0;
            o_data_r  <= 24'd0;
        end else begin
            o_valid_l <= pipe_valid[MUL_LAT-1] & ~pipe_tag[MUL_LAT-1];
            o_valid_r <= pipe_valid[MUL_LAT-1] & pipe_tag[MUL_LAT-1];
            if (pipe_valid[MUL_LAT-1] && !pipe_tag[MUL_LAT-1]) begin
                o_data_l <= pipe_res[MUL_LAT-1];
            end
            if (pipe_valid[MUL_LAT-1] && pipe_tag[MUL_LAT-1]) begin
                o_data_r <= pipe_res[MUL_LAT-1];
            end
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            pipe_any = pipe_any | pipe_valid[i];
        end
    end

    assign busy = buf_l_full | buf_r_full | pipe_any;

endmodule

// File: tb/tb_mixer_mult_sched.sv
// Randomized self-checking bench for mixer_mult_sched against a transaction-level reference model.
module tb_mixer_mult_sched;

    localparam int MUL_LAT = 2;
    localparam bit RR_INIT = 1'b0;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] lo_sample = '0;
    logic        lo_strobe = 1'b0;
    logic        req_l = 1'b0;
    logic [23:0] data_l = '0;
    logic        ack_l;
    logic        req_r = 1'b0;
    logic [23:0] data_r = '0;
    logic        ack_r;
    logic [23:0] o_data_l;
    logic        o_valid_l;
    logic [23:0] o_data_r;
    logic        o_valid_r;
    logic        busy;
    logic [1:0]  overrun;
    logic        clr_overrun = 1'b0;

    int numCompared = 0;
    int numMismatched = 0;

    mixer_mult_sched #(.MUL_LAT(MUL_LAT), .RR_INIT(RR_INIT)) dut (
        .mclk(mclk), .reset(reset),
        .lo_sample(lo_sample), .lo_strobe(lo_strobe),
        .req_l(req_l), .data_l(data_l), .ack_l(ack_l),
        .req_r(req_r), .data_r(data_r), .ack_r(ack_r),
        .o_data_l(o_data_l), .o_valid_l(o_valid_l),
        .o_data_r(o_data_r), .o_valid_r(o_valid_r),
        .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 mclk = ~mclk;

    // Reference model: buffered samples, tie-break pointer and a list of results due at given edges.
    typedef struct {
        int          due;
        int          ch;
        logic [23:0] val;
    } result_t;

    result_t     pend[$];
    bit          mFull[2];
    logic [23:0] mBuf[2];
    int          mRr;
    logic [1:0]  mOver;
    bit          mAck[2];
    bit          mValid[2];
    logic [23:0] mOut[2];
    int          cyc;

    function automatic logic [23:0] mixValue(input logic [15:0] lo, input logic [23:0] d);
        longint p;
        longint q;
        p = longint'($signed(lo)) * longint'($signed(d));
        q = p >>> 15;
`ifdef MIXER_SCHED_SAT_EN
        if (q > 64'sd8388607) q = 64'sd8388607;
        if (q < -64'sd8388608) q = -64'sd8388608;
`endif
        return q[23:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("ack_l", 32'(ack_l), 32'(mAck[0]));
        checkOutput("ack_r", 32'(ack_r), 32'(mAck[1]));
        checkOutput("o_valid_l", 32'(o_valid_l), 32'(mValid[0]));
        checkOutput("o_valid_r", 32'(o_valid_r), 32'(mValid[1]));
        checkOutput("o_data_l", 32'(o_data_l), 32'(mOut[0]));
        checkOutput("o_data_r", 32'(o_data_r), 32'(mOut[1]));
        checkOutput("busy", 32'(busy), 32'(mFull[0] || mFull[1] || pend.size() > 0));
        checkOutput("overrun", 32'(overrun), 32'(mOver));
    endtask

    task automatic applyStimulus(input logic rl, input logic [23:0] dl,
                                 input logic rqr, input logic [23:0] dr,
                                 input logic stb, input logic [15:0] lo,
                                 input logic clr);
        int          g;
        logic [1:0]  drops;
        logic        reqs[2];
        logic [23:0] datas[2];
        req_l = rl; data_l = dl; req_r = rqr; data_r = dr;
        lo_strobe = stb; lo_sample = lo; clr_overrun = clr;
        reqs[0] = rl; reqs[1] = rqr; datas[0] = dl; datas[1] = dr;
        cyc++;
        g = -1;
        if (stb) begin
            if (mFull[0] && mFull[1]) g = mRr;
            else if (mFull[0]) g = 0;
            else if (mFull[1]) g = 1;
        end
        if (g >= 0) begin
            pend.push_back('{cyc + MUL_LAT, g, mixValue(lo, mBuf[g])});
            mFull[g] = 1'b0;
            mRr = 1 - g;
        end
        drops = 2'b00;
        for (int c = 0; c < 2; c++) begin
            mAck[c] = 1'b0;
            if (reqs[c]) begin
                if (!mFull[c]) begin
                    mFull[c] = 1'b1;
                    mBuf[c] = datas[c];
                    mAck[c] = 1'b1;
                end else begin
                    drops[c] = 1'b1;
                end
            end
        end
        mOver = (clr ? 2'b00 : mOver) | drops;
        @(posedge mclk);
        #1;
        mValid[0] = 1'b0;
        mValid[1] = 1'b0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            mValid[pend[0].ch] = 1'b1;
            mOut[pend[0].ch] = pend[0].val;
            void'(pend.pop_front());
        end
        checkAll();
    endtask

    task automatic idle(input int n, input logic [15:0] lo);
        for (int i = 0; i < n; i++) applyStimulus(0, 24'h0, 0, 24'h0, 1, lo, 0);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req_l = 0; req_r = 0; lo_strobe = 0; clr_overrun = 0;
        pend.delete();
        for (int c = 0; c < 2; c++) begin
            mFull[c] = 0; mBuf[c] = '0; mAck[c] = 0; mValid[c] = 0; mOut[c] = '0;
        end
        mRr = int'(RR_INIT);
        mOver = 2'b00;
        #1;
        checkAll();
        @(posedge mclk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        cyc = 0;
        resetDut();

        // Basic left transaction
        applyStimulus(1, 24'h200000, 0, 24'h0, 1, 16'h4000, 0);
        idle(MUL_LAT + 2, 16'h4000);
        checkOutput("basic_const", 32'(o_data_l), 32'h100000);

        // Negative operands on the right channel
        applyStimulus(0, 24'h0, 1, 24'h000001, 1, 16'h8000, 0);
        idle(MUL_LAT + 2, 16'h8000);
        checkOutput("neg_const", 32'(o_data_r), 32'hFFFFFF);

        // Contention, twice in a row: left must win both times
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 24'h123456, 1, 24'h654321, 1, 16'h2000, 0);
            idle(MUL_LAT + 3, 16'h2000);
        end

        // Strobe gating and overrun, then clear
        applyStimulus(1, 24'h0ABCDE, 0, 24'h0, 0, 16'h1000, 0);
        applyStimulus(1, 24'h7FFFFF, 0, 24'h0, 0, 16'h1000, 0);
        checkOutput("ovr_const", 32'(overrun), 32'h1);
        applyStimulus(0, 24'h0, 0, 24'h0, 0, 16'h1000, 0);
        idle(MUL_LAT + 2, 16'h1000);
        applyStimulus(0, 24'h0, 0, 24'h0, 0, 16'h1000, 1);
        checkOutput("clr_const", 32'(overrun), 32'h0);

        // Saturation corner
        applyStimulus(1, 24'h800000, 0, 24'h0, 1, 16'h8000, 0);
        idle(MUL_LAT + 2, 16'h8000);
`ifdef MIXER_SCHED_SAT_EN
        checkOutput("sat_const", 32'(o_data_l), 32'h7FFFFF);
`else
        checkOutput("sat_const", 32'(o_data_l), 32'h800000);
`endif

        // Reset one cycle after issue drops the in-flight result
        applyStimulus(1, 24'h111111, 0, 24'h0, 0, 16'h3000, 0);
        applyStimulus(0, 24'h0, 0, 24'h0, 1, 16'h3000, 0);
        applyStimulus(0, 24'h0, 0, 24'h0, 0, 16'h3000, 0);
        resetDut();
        checkOutput("rst_busy", 32'(busy), 32'h0);
        applyStimulus(0, 24'h0, 0, 24'h0, 0, 16'h3000, 0);
        applyStimulus(0, 24'h0, 0, 24'h0, 0, 16'h3000, 0);
        applyStimulus(0, 24'h0, 0, 24'h0, 0, 16'h3000, 0);
        applyStimulus(1, 24'h200000, 0, 24'h0, 1, 16'h4000, 0);
        idle(MUL_LAT + 2, 16'h4000);
        checkOutput("post_rst_const", 32'(o_data_l), 32'h100000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [23:0] dl;
            logic [23:0] dr;
            logic [15:0] lo;
            dl = ($urandom_range(0, 9) == 0) ? 24'h800000 : 24'($urandom);
            dr = ($urandom_range(0, 9) == 0) ? 24'h800000 : 24'($urandom);
            lo = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            applyStimulus(logic'($urandom_range(0, 2) == 0), dl,
                          logic'($urandom_range(0, 2) == 0), dr,
                          logic'($urandom_range(0, 1)), lo,
                          logic'($urandom_range(0, 19) == 0));
            if (n % 1000 == 999) resetDut();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/mixer_mult_sched.md
Name: mixer_mult_sched

Overview:
- Scheduler that time-shares one signed 16x24 multiplier between the left and right mixer channels.
- Each channel hands in one 24-bit sample per request pulse. The block buffers it, arbitrates round-robin, and issues it to the multiplier with the current oscillator (LO) sample.
- Issue happens only on oscillator update strobes. The block returns a per-channel mixed sample with a valid pulse.
- It sits between the I2S receive path and the downstream LPF/transmit path.

Parameters:
- MUL_LAT, 2, multiplier pipeline depth in mclk cycles from issue to result (1..4).
- RR_INIT, 0, channel favoured first after reset (0=L, 1=R).

Ports:
- mclk  in  1  master clock; everything is registered on rising edge.
- reset  in  1  asynchronous, active-high reset.
- lo_sample  in  16  signed LO sample from the oscillator.
- lo_strobe  in  1  1-cycle strobe; issue is permitted only in cycles where it is high.
- req_l  in  1  1-cycle pulse: data_l is valid.
- data_l  in  24  signed left input sample.
- ack_l  out  1  1-cycle pulse: left sample accepted.
- req_r  in  1  1-cycle pulse: data_r is valid.
- data_r  in  24  signed right input sample.
- ack_r  out  1  1-cycle pulse: right sample accepted.
- o_data_l  out  24  left mixed result.
- o_valid_l  out  1  1-cycle result strobe for left.
- o_data_r  out  24  right mixed result.
- o_valid_r  out  1  1-cycle result strobe for right.
- busy  out  1  high when any buffer is full or any result is in flight.
- overrun  out  2  sticky drop flags, [0]=L, [1]=R.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, active-high) clears:
  - both buffers to empty;
  - the pipeline, so in-flight results are discarded and produce no o_valid;
  - rr pointer to RR_INIT;
  - all outputs to 0 (acks, valids, o_data_*, busy, overrun).
- Capture: req_x at edge k with buffer x empty, or emptying at edge k by issue:
  - data_x is latched and the buffer is marked full;
  - ack_x is high for the single cycle after edge k.
- Drop: req_x while buffer x is full and not issued at that edge:
  - the sample is dropped with no ack;
  - overrun[x] is set after that edge;
  - the held sample is unchanged.
- Issue, at most one per cycle, only when lo_strobe=1:
  - Only L full: issue L. Only R full: issue R.
  - Both full: issue the channel pointed to by rr, then rr points to the other channel.
  - A single-channel grant sets rr to the other channel.
  - The issued buffer empties at that edge; lo_sample is sampled at the same edge.
- Arithmetic:
  - p = signed(lo_sample) * signed(buffer), 40-bit two's complement.
  - result = p[38:15].
  - The channel tag travels with the result through the MUL_LAT stage pipeline.
- Output timing:
  - Issue at edge k gives o_valid_x high and o_data_x updated after edge k+MUL_LAT.
  - o_data_x holds its value between valids.
  - Both channels can never be valid in the same cycle.
- Latency: req to o_valid is MUL_LAT+1 edges minimum, when lo_strobe is high the cycle after capture.
- busy = buf_l_full | buf_r_full | any pipeline stage valid.
- clr_overrun and a new overrun on the same edge: the set wins.
- Simultaneous req_l and req_r are both captured; arbitration applies only at issue.

Optional Feature:
- Macro MIXER_SCHED_SAT_EN.
- Defined: if p[39] != p[38], the result saturates to 0x7FFFFF when p[39]=0, else 0x800000. The only case is lo=0x8000 with data=0x800000.
- Undefined: plain p[38:15] truncation, which wraps.

Test Plan:
- Basic left, MUL_LAT=2, lo_strobe held 1:
  - stimulus: lo=0x4000, req_l with data_l=0x200000 at edge k;
  - response: ack_l after k, o_valid_l after k+3, o_data_l=0x100000.
- Negative operands: lo=0x8000, data_r=0x000001 -> o_data_r=0xFFFFFF.
- Contention, RR_INIT=0, lo_strobe=1:
  - stimulus: req_l and req_r on the same edge k;
  - response: L valid after k+3, R valid after k+4; repeat the pair and the order stays L first, because rr returned to L after granting R.
- Strobe gating and overrun:
  - stimulus: lo_strobe=0, req_l twice;
  - response: second req gets no ack, overrun=2'b01, the first sample is still issued on the next lo_strobe; clr_overrun then gives overrun=0.
- Saturation: lo=0x8000, data_l=0x800000 -> 0x800000 without MIXER_SCHED_SAT_EN, 0x7FFFFF with it.
- Reset mid-flight: assert reset one cycle after issue -> no o_valid, busy=0, buffers empty, next req behaves as after power-up.
